// File: rtl/conv_1x1_sched_11_pkg.sv
// Shared types and helpers for the layer-11 1x1 convolution scheduler.
// Counter widths are derived from the parameters through cnt_w.
package conv_1x1_sched_11_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Width of a counter over n values; never below one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_1x1_flag_delay.sv
// Fixed-length shift register that lines the accumulator flags up with
// the multiplier output.
module conv_1x1_flag_delay #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/conv_1x1_sched_11.sv
// Layer-11 1x1 convolution sequencer: loads one output channel's weights,
// then streams every input feature map, tagging products for the accumulator.
module conv_1x1_sched_11
    import conv_1x1_sched_11_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 64,
    parameter int IMAGE_HEIGHT    = 64,
    parameter int CHANNEL_NUM_IN  = 256,
    parameter int CHANNEL_NUM_OUT = 256,
    parameter int MUL_LATENCY     = 3
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    input  logic                                w_src_valid,
    input  logic [DATA_WIDTH-1:0]               w_src_data,
    output logic                                w_src_ready,
    input  logic                                pxl_src_valid,
    input  logic [DATA_WIDTH-1:0]               pxl_src_data,
    output logic                                pxl_src_ready,
    output logic                                valid_weight_in,
    output logic [DATA_WIDTH-1:0]               weight_in,
    output logic                                valid_in,
    output logic [DATA_WIDTH-1:0]               pxl_in,
    output logic [cnt_w(CHANNEL_NUM_OUT)-1:0]   ch_out_idx,
    output logic                                acc_first,
    output logic                                acc_last
);

    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int PXW = cnt_w(IMAGE_SIZE);
    localparam int CIW = cnt_w(CHANNEL_NUM_IN);
    localparam int COW = cnt_w(CHANNEL_NUM_OUT);

    state_t state, state_nxt;

    logic [PXW-1:0] px;
    logic [CIW-1:0] ci;
    logic [CIW-1:0] wc;
    logic [COW-1:0] co;

    logic w_hs, p_hs;
    logic px_end, ci_end, co_end, wc_end;
    logic [1:0] flag_d, flag_q;

    assign w_src_ready   = (state == ST_LOAD_W);
    assign pxl_src_ready = (state == ST_STREAM);
    assign busy          = (state == ST_LOAD_W) || (state == ST_STREAM);
    assign done          = (state == ST_DONE);

    assign w_hs = w_src_valid & w_src_ready;
    assign p_hs = pxl_src_valid & pxl_src_ready;

    assign px_end = (px == PXW'(IMAGE_SIZE - 1));
    assign ci_end = (ci == CIW'(CHANNEL_NUM_IN - 1));
    assign co_end = (co == COW'(CHANNEL_NUM_OUT - 1));
    assign wc_end = (wc == CIW'(CHANNEL_NUM_IN - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = ST_LOAD_W;
            ST_LOAD_W: if (w_hs && wc_end) state_nxt = ST_STREAM;
            ST_STREAM: begin
                if (p_hs && px_end && ci_end)
                    state_nxt = co_end ? ST_DONE : ST_LOAD_W;
            end
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            px              <= '0;
            ci              <= '0;
            wc              <= '0;
            co              <= '0;
            valid_weight_in <= 1'b0;
            weight_in       <= '0;
            valid_in        <= 1'b0;
            pxl_in          <= '0;
        end else begin
            state           <= state_nxt;
            valid_weight_in <= w_hs;
            valid_in        <= p_hs;
            if (w_hs) weight_in <= w_src_data;
            if (p_hs) pxl_in <= pxl_src_data;

            if (state == ST_IDLE && start) begin
                px <= '0;
                ci <= '0;
                wc <= '0;
                co <= '0;
            end

            if (w_hs) wc <= wc_end ? '0 : wc + 1'b1;

            // Channel-major walk; co advances as the next LOAD_W is entered.
            if (p_hs) begin
                if (px_end) begin
                    px <= '0;
                    if (ci_end) begin
                        ci <= '0;
                        if (!co_end) co <= co + 1'b1;
                    end else begin
                        ci <= ci + 1'b1;
                    end
                end else begin
                    px <= px + 1'b1;
                end
            end
        end
    end

    assign ch_out_idx = co;

    assign flag_d = p_hs ? {ci == '0, ci_end} : 2'b00;

    conv_1x1_flag_delay #(
        .DEPTH (MUL_LATENCY + 1),
        .WIDTH (2)
    ) u_flag_delay (
        .clk   (clk),
        .reset (reset),
        .d     (flag_d),
        .q     (flag_q)
    );

    assign acc_first = flag_q[1];
    assign acc_last  = flag_q[0];

endmodule
